// File: rtl/grf_mp_pkg.sv
// Shared sizing defaults and the trace-entry layout for the multi-port register file.
package grf_mp_pkg;

  localparam int GRF_DATA_W = 32;
  localparam int GRF_ADDR_W = 5;
  localparam int GRF_PC_W   = 32;
  localparam int DEPTH      = 2 ** GRF_ADDR_W;

  typedef struct packed {
    logic [GRF_PC_W-1:0]   pc;
    logic [GRF_ADDR_W-1:0] addr;
    logic [GRF_DATA_W-1:0] data;
  } trc_entry_t;

endpackage

// File: rtl/grf_trc_fifo.sv
// Multi-push, single-pop trace FIFO with a registered head and a sticky drop flag.
module grf_trc_fifo #(
  parameter int PC_W   = 32,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32,
  parameter int NUM_WR = 2,
  parameter int DEPTH  = 8
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic [NUM_WR-1:0]                        i_push,
  input  logic [NUM_WR*(PC_W+ADDR_W+DATA_W)-1:0]   i_entry,
  input  logic                                     i_ready,
  output logic                                     o_valid,
  output logic [PC_W-1:0]                          o_pc,
  output logic [ADDR_W-1:0]                        o_addr,
  output logic [DATA_W-1:0]                        o_data,
  output logic                                     o_ovf
);

  localparam int E_W = PC_W + ADDR_W + DATA_W;
  localparam int PW  = $clog2(DEPTH);

  logic [E_W-1:0] r_mem [DEPTH];
  logic [PW-1:0]  r_wptr;
  logic [PW-1:0]  r_rptr;
  logic [PW:0]    r_count;
  logic           r_valid;
  logic           r_ovf;
  logic [E_W-1:0] r_head;

  logic              w_pop;
  logic [PW:0]       w_free;
  logic [PW:0]       w_acc;
  logic [PW:0]       w_count_nxt;
  logic [PW:0]       w_left;
  logic [NUM_WR-1:0] w_take;
  logic [PW-1:0]     w_slot [NUM_WR];
  logic              w_drop;
  logic [E_W-1:0]    w_first;
  logic [PW-1:0]     w_rptr_nxt;
  logic [E_W-1:0]    w_head_nxt;

  assign w_pop  = r_valid && i_ready;
  assign w_free = (PW+1)'(DEPTH) - r_count;

  // Free space is judged before this cycle's pop; pushes beyond it are dropped in port order.
  always_comb begin
    w_acc   = '0;
    w_take  = '0;
    w_drop  = 1'b0;
    w_first = '0;
    for (int j = 0; j < NUM_WR; j++) begin
      w_slot[j] = r_wptr + w_acc[PW-1:0];
      if (i_push[j]) begin
        if (w_acc < w_free) begin
          w_take[j] = 1'b1;
          w_acc     = w_acc + (PW+1)'(1);
        end else begin
          w_drop = 1'b1;
        end
      end
    end
    for (int j = NUM_WR - 1; j >= 0; j--) begin
      if (w_take[j]) w_first = i_entry[j*E_W +: E_W];
    end
  end

  assign w_left      = r_count - (PW+1)'(w_pop);
  assign w_count_nxt = w_left + w_acc;
  assign w_rptr_nxt  = r_rptr + PW'(w_pop);

  // When the FIFO drains to nothing, the new head can only come from this cycle's first push.
  always_comb begin
    w_head_nxt = r_head;
    if (w_count_nxt != '0) begin
      if (w_left == '0) w_head_nxt = w_first;
      else              w_head_nxt = r_mem[w_rptr_nxt];
    end
  end

  always_ff @(posedge clk) begin
    for (int j = 0; j < NUM_WR; j++) begin
      if (w_take[j]) r_mem[w_slot[j]] <= i_entry[j*E_W +: E_W];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_valid <= 1'b0;
      r_ovf   <= 1'b0;
      r_head  <= '0;
    end else begin
      r_wptr  <= r_wptr + w_acc[PW-1:0];
      r_rptr  <= w_rptr_nxt;
      r_count <= w_count_nxt;
      r_valid <= (w_count_nxt != '0);
      r_ovf   <= r_ovf | w_drop;
      r_head  <= w_head_nxt;
    end
  end

  assign o_valid = r_valid;
  assign o_ovf   = r_ovf;
  assign {o_pc, o_addr, o_data} = r_head;

endmodule

// File: rtl/grf_mp.sv
// Multi-port general register file with write bypass, pending-write scoreboard and write trace.
module grf_mp
  import grf_mp_pkg::*;
#(
  parameter int DATA_W    = GRF_DATA_W,
  parameter int ADDR_W    = GRF_ADDR_W,
  parameter int NUM_RD    = 2,
  parameter int NUM_WR    = 2,
  parameter int ZERO_REG  = 1,
  parameter int BYPASS    = 1,
  parameter int PC_W      = GRF_PC_W,
  parameter int TRC_DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic [NUM_WR-1:0]        we,
  input  logic [NUM_WR*ADDR_W-1:0] wa,
  input  logic [NUM_WR*DATA_W-1:0] wd,
  input  logic [NUM_WR*PC_W-1:0]   wpc,
  input  logic                     sb_set,
  input  logic [ADDR_W-1:0]        sb_addr,
  output logic                     trc_valid,
  input  logic                     trc_ready,
  output logic [PC_W-1:0]          trc_pc,
  output logic [ADDR_W-1:0]        trc_addr,
  output logic [DATA_W-1:0]        trc_data,
  output logic                     trc_ovf
);

  localparam int NREG = 2 ** ADDR_W;
  localparam int E_W  = PC_W + ADDR_W + DATA_W;

  logic [DATA_W-1:0] r_rf [NREG];
  logic [NREG-1:0]   r_busy;

  logic [NREG-1:0]       w_busy_nxt;
  logic [ADDR_W-1:0]     w_ra [NUM_RD];
  logic [DATA_W-1:0]     w_rv [NUM_RD];
  logic [NUM_WR*E_W-1:0] w_entries;

  // Later ports overwrite earlier ones, so the highest matching index wins.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int a = 0; a < NREG; a++) r_rf[a] <= '0;
    end else begin
      for (int j = 0; j < NUM_WR; j++) begin
        if (we[j] && !((ZERO_REG != 0) && (wa[j*ADDR_W +: ADDR_W] == '0)))
          r_rf[wa[j*ADDR_W +: ADDR_W]] <= wd[j*DATA_W +: DATA_W];
      end
    end
  end

  // A new producer marking a register pending outranks a write retiring the old one.
  always_comb begin
    w_busy_nxt = r_busy;
    for (int j = 0; j < NUM_WR; j++) begin
      if (we[j]) w_busy_nxt[wa[j*ADDR_W +: ADDR_W]] = 1'b0;
    end
    if (sb_set) w_busy_nxt[sb_addr] = 1'b1;
    if (ZERO_REG != 0) w_busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_busy <= '0;
    else        r_busy <= w_busy_nxt;
  end

  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      w_ra[i] = rd_addr[i*ADDR_W +: ADDR_W];
      w_rv[i] = r_rf[w_ra[i]];
      if (BYPASS != 0) begin
        for (int j = 0; j < NUM_WR; j++) begin
          if (we[j] && (wa[j*ADDR_W +: ADDR_W] == w_ra[i])) w_rv[i] = wd[j*DATA_W +: DATA_W];
        end
      end
      if ((ZERO_REG != 0) && (w_ra[i] == '0)) w_rv[i] = '0;
      rd_data[i*DATA_W +: DATA_W] = w_rv[i];
      rd_busy[i] = r_busy[w_ra[i]];
    end
  end

  always_comb begin
    w_entries = '0;
    for (int j = 0; j < NUM_WR; j++) begin
      w_entries[j*E_W +: E_W] = {wpc[j*PC_W +: PC_W], wa[j*ADDR_W +: ADDR_W], wd[j*DATA_W +: DATA_W]};
    end
  end

  grf_trc_fifo #(
    .PC_W   (PC_W),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .NUM_WR (NUM_WR),
    .DEPTH  (TRC_DEPTH)
  ) u_trc_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (we),
    .i_entry (w_entries),
    .i_ready (trc_ready),
    .o_valid (trc_valid),
    .o_pc    (trc_pc),
    .o_addr  (trc_addr),
    .o_data  (trc_data),
    .o_ovf   (trc_ovf)
  );

endmodule

// File: doc/grf_mp.md
Name: grf_mp

Overview:
Parametrised multi-port general register file, the successor to the single-write, two-read GRF in the CPU datapath. Adds configurable width, depth, read and write port counts, and same-cycle write-to-read bypass. Adds a per-register pending-write scoreboard for hazard detection. Replaces simulation-only write printing with a buffered write-trace stream, exported through a valid/ready FIFO to the testbench or trace logger.

Parameters:
DATA_W, 32, register data width
ADDR_W, 5, register address width; depth = 2**ADDR_W
NUM_RD, 2, number of read ports
NUM_WR, 2, number of write ports (1..4)
ZERO_REG, 1, 1 = register 0 reads 0, write-protected, never busy
BYPASS, 1, 1 = read returns same-cycle write data
PC_W, 32, PC tag width carried in trace
TRC_DEPTH, 8, trace FIFO entries (power of 2, >= NUM_WR)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
rd_addr  in  NUM_RD*ADDR_W  read addresses, port i at slice i
rd_data  out  NUM_RD*DATA_W  read data, combinational
rd_busy  out  NUM_RD  scoreboard busy bit of each read address
we  in  NUM_WR  write enables
wa  in  NUM_WR*ADDR_W  write addresses
wd  in  NUM_WR*DATA_W  write data
wpc  in  NUM_WR*PC_W  PC of the instruction writing, trace only
sb_set  in  1  mark register sb_addr pending
sb_addr  in  ADDR_W  register to mark pending
trc_valid  out  1  trace head valid
trc_ready  in  1  consumer accepts trace head
trc_pc  out  PC_W  trace head PC
trc_addr  out  ADDR_W  trace head register
trc_data  out  DATA_W  trace head data
trc_ovf  out  1  sticky: a trace entry was dropped

Behaviour:
- Reset (reset=0, asynchronous): all registers 0, all busy bits 0, FIFO empty, trc_valid=0, trc_ovf=0. Trace head outputs are 0. A reset mid-operation discards FIFO contents and pending bits immediately.
- Read: rd_data[i] = RF[rd_addr[i]], combinational with 0 cycle latency.
  - ZERO_REG=1 and address 0 gives 0.
  - BYPASS=1 and any we[j] with wa[j]==rd_addr[i] this cycle gives the wd of the highest-index matching port.
  - Address 0 under ZERO_REG is never bypassed.
- Write: at posedge, RF[wa[j]] <= wd[j] for each we[j].
  - Same address on several ports: highest index wins.
  - Writes to reg 0 under ZERO_REG do not change storage.
- Scoreboard: busy[a] is set at posedge by sb_set with sb_addr=a, and cleared at posedge by any enabled write to a.
  - Set and clear on the same address in the same cycle: set wins (new producer).
  - Under ZERO_REG, busy[0] is constant 0 and sb_set to 0 is ignored.
  - rd_busy[i] = busy[rd_addr[i]], reflecting registered state only (not same-cycle set/clear).
- Trace FIFO: each enabled write pushes {wpc, wa, wd}, including writes to reg 0, in port order 0..NUM_WR-1. A cycle may push up to NUM_WR entries.
  - free = TRC_DEPTH - count, sampled before this cycle's pop.
  - If pushes exceed free, accept the first free pushes in port order, drop the rest, and set trc_ovf; it stays set until reset.
  - Pop happens when trc_valid && trc_ready. Head outputs are registered from storage and valid the cycle after the first push (1-cycle latency).
  - Push and pop in the same cycle: count += pushes - pop. Pointers wrap modulo TRC_DEPTH.
  - Empty: trc_valid=0, head outputs hold last value. trc_ready while empty has no effect.
  - Head data is stable while trc_valid && !trc_ready.

Decomposition:
- Shared package: trace-entry struct {pc, addr, data} widths, and a localparam DEPTH = 2**ADDR_W.
- One sub-module, grf_trc_fifo: a multi-push (up to NUM_WR), single-pop FIFO with overflow flag.
- Storage, bypass and scoreboard stay in grf_mp.

Test Plan:
1. Reset low mid-stream with 3 trace entries and busy[5]=1 -> immediately trc_valid=0, rd_busy=0, all reads 0; after release, reads of reg 7 give 0.
2. we=2'b11, wa={3,3}, wd={0xBBBB,0xAAAA}; read port 0 addr 3 same cycle -> rd_data=0xBBBB (bypass). Next cycle 0xBBBB from storage; trace holds 2 entries, 0xAAAA first.
3. Write 0x1234 to reg 0 -> reads of reg 0 stay 0; one trace entry with addr 0 and data 0x1234 is emitted.
4. sb_set addr 9 at cycle n -> rd_busy=1 from n+1. Write to reg 9 with sb_set addr 9 in the same cycle -> busy stays 1. Write alone -> busy 0 next cycle.
5. trc_ready=0, 4 cycles of dual writes (TRC_DEPTH=8) -> 8 entries accepted, trc_ovf=0. One more dual write -> both dropped, trc_ovf=1 and it stays 1 after draining.
6. FIFO holds 7 entries, trc_ready=1, dual write -> first entry accepted, second dropped (free=1 pre-pop), and the pop occurs. Ordering of drained PCs matches push order.
